te_block_scheduler: RTL and testbench

Output scheduler between the multiple-retirement block generator and a single-port trace encoder. It accepts up to N trace blocks per cycle on parallel lanes and buffers them in a circular queue. It drains them one per cycle, in lane order, over a valid/ready handshake. It reports overflow because the upstream generator has no backpressure input.

---
 rtl/te_block_scheduler.sv | 145 ++++++++++++++
 tb/tb_te_block_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/te_block_scheduler.sv
// Trace block output scheduler: compacts up to N parallel blocks per cycle into a
// circular queue and drains one per cycle. Optional drop counter: TE_SCHED_DROP_COUNT_EN.
module te_block_scheduler #(
  parameter int N           = 1,
  parameter int DEPTH       = 8,
  parameter int IRETIRE_LEN = 3,
  parameter int ITYPE_LEN   = 4,
  parameter int CAUSE_LEN   = 6,
  parameter int XLEN        = 32,
  parameter int PRIV_LEN    = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [N-1:0]                    valid_i,
  input  logic [N-1:0][IRETIRE_LEN-1:0]   iretire_i,
  input  logic [N-1:0]                    ilastsize_i,
  input  logic [N-1:0][ITYPE_LEN-1:0]     itype_i,
  input  logic [N-1:0][CAUSE_LEN-1:0]     cause_i,
  input  logic [N-1:0][XLEN-1:0]          tval_i,
  input  logic [N-1:0][PRIV_LEN-1:0]      priv_i,
  input  logic [N-1:0][XLEN-1:0]          iaddr_i,
  input  logic                            flush_i,
  input  logic                            clear_overflow_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [IRETIRE_LEN-1:0]          out_iretire_o,
  output logic                            out_ilastsize_o,
  output logic [ITYPE_LEN-1:0]            out_itype_o,
  output logic [CAUSE_LEN-1:0]            out_cause_o,
  output logic [XLEN-1:0]                 out_tval_o,
  output logic [PRIV_LEN-1:0]             out_priv_o,
  output logic [XLEN-1:0]                 out_iaddr_o,
  output logic                            in_ready_o,
  output logic [$clog2(DEPTH):0]          usage_o,
  output logic                            overflow_o,
  output logic [15:0]                     dropped_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(N + 1);

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        iaddr;
  } entry_t;

  entry_t              mem [DEPTH];
  entry_t [N-1:0]      lane_entry;
  entry_t              head;
  logic [PW-1:0]       rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic [CW-1:0]       free_slots, g_ext;
  logic [N-1:0][GW-1:0] offset;
  logic [GW-1:0]       g;
  logic                accept, push, pop, drop, overflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign lane_entry[gi] = {iretire_i[gi], ilastsize_i[gi], itype_i[gi], cause_i[gi],
                               tval_i[gi], priv_i[gi], iaddr_i[gi]};
    end
  endgenerate

  // Running popcount: offset[k] is the number of valid lanes below k.
  always_comb begin
    logic [GW-1:0] acc;
    acc = '0;
    for (int k = 0; k < N; k++) begin
      offset[k] = acc;
      acc = acc + GW'(valid_i[k]);
    end
    g = acc;
  end

  assign free_slots = CW'(DEPTH) - count_reg;
  assign g_ext      = CW'(g);
  assign accept     = (g != '0) && (g_ext <= free_slots);
  assign push       = accept && !flush_i;
  assign drop       = (g != '0) && !accept && !flush_i;
  assign pop        = (count_reg != '0) && out_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int k = 0; k < N; k++) begin
        if (valid_i[k]) mem[wr_ptr_reg + PW'(offset[k])] <= lane_entry[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (flush_i) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PW'(g);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        count_reg <= count_reg + (push ? g_ext : '0) - (pop ? CW'(1) : '0);
      end
      if (drop)                  overflow_reg <= 1'b1;
      else if (clear_overflow_i) overflow_reg <= 1'b0;
    end
  end

  // Head is forced to zero while empty so stale slots never leak to the encoder.
  assign out_valid_o     = (count_reg != '0);
  assign head            = out_valid_o ? mem[rd_ptr_reg] : '0;
  assign out_iretire_o   = head.iretire;
  assign out_ilastsize_o = head.ilastsize;
  assign out_itype_o     = head.itype;
  assign out_cause_o     = head.cause;
  assign out_tval_o      = head.tval;
  assign out_priv_o      = head.priv;
  assign out_iaddr_o     = head.iaddr;
  assign in_ready_o      = (free_slots >= CW'(N));
  assign usage_o         = count_reg;
  assign overflow_o      = overflow_reg;

`ifdef TE_SCHED_DROP_COUNT_EN
  logic [15:0] drop_cnt_reg;
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_cnt_reg} + 17'(g);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   drop_cnt_reg <= '0;
    else if (drop) drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
  assign dropped_cnt_o = drop_cnt_reg;
`else
  assign dropped_cnt_o = '0;
`endif

endmodule

// File: tb/tb_te_block_scheduler.sv
// Bench for te_block_scheduler (N=2, DEPTH=4): directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_te_block_scheduler;

  typedef struct packed {
    logic [2:0]  iretire;
    logic        ilastsize;
    logic [3:0]  itype;
    logic [5:0]  cause;
    logic [31:0] tval;
    logic [1:0]  priv;
    logic [31:0] iaddr;
  } blk_t;

  logic clk = 0, rst_n = 0;
  logic [1:0] valid = '0;
  logic flush = 0, clr = 0, ready = 0;
  blk_t [1:0] lane_in;
  logic [1:0][2:0]  iretire_s;
  logic [1:0]       ilastsize_s;
  logic [1:0][3:0]  itype_s;
  logic [1:0][5:0]  cause_s;
  logic [1:0][31:0] tval_s, iaddr_s;
  logic [1:0][1:0]  priv_s;
  logic        out_valid, in_ready, overflow, out_ilastsize;
  logic [2:0]  out_iretire, usage;
  logic [3:0]  out_itype;
  logic [5:0]  out_cause;
  logic [31:0] out_tval, out_iaddr;
  logic [1:0]  out_priv;
  logic [15:0] dropped;
  blk_t        head_obs;

  int n_checks = 0, n_pass = 0;
  blk_t mq[$];
  bit   m_ovf = 0;
  int   m_drop = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_drv
    assign iretire_s[k]   = lane_in[k].iretire;
    assign ilastsize_s[k] = lane_in[k].ilastsize;
    assign itype_s[k]     = lane_in[k].itype;
    assign cause_s[k]     = lane_in[k].cause;
    assign tval_s[k]      = lane_in[k].tval;
    assign priv_s[k]      = lane_in[k].priv;
    assign iaddr_s[k]     = lane_in[k].iaddr;
  end
  assign head_obs = {out_iretire, out_ilastsize, out_itype, out_cause, out_tval, out_priv, out_iaddr};

  te_block_scheduler #(.N(2), .DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid),
    .iretire_i(iretire_s), .ilastsize_i(ilastsize_s), .itype_i(itype_s), .cause_i(cause_s),
    .tval_i(tval_s), .priv_i(priv_s), .iaddr_i(iaddr_s),
    .flush_i(flush), .clear_overflow_i(clr),
    .out_valid_o(out_valid), .out_ready_i(ready),
    .out_iretire_o(out_iretire), .out_ilastsize_o(out_ilastsize), .out_itype_o(out_itype),
    .out_cause_o(out_cause), .out_tval_o(out_tval), .out_priv_o(out_priv), .out_iaddr_o(out_iaddr),
    .in_ready_o(in_ready), .usage_o(usage), .overflow_o(overflow), .dropped_cnt_o(dropped)
  );

  function automatic blk_t rnd_blk(logic [31:0] addr);
    blk_t b;
    b.iretire = 3'($urandom); b.ilastsize = 1'($urandom); b.itype = 4'($urandom);
    b.cause = 6'($urandom); b.tval = $urandom; b.priv = 2'($urandom); b.iaddr = addr;
    return b;
  endfunction

  function automatic int exp_drop_after(int g);
`ifdef TE_SCHED_DROP_COUNT_EN
    return (m_drop + g > 65535) ? 65535 : m_drop + g;
`else
    return 0;
`endif
  endfunction

  // Advances the reference model by one clock using the currently driven inputs.
  task automatic tick();
    int g;
    g = int'(valid[0]) + int'(valid[1]);
    if (flush) begin
      mq.delete();
      if (clr) m_ovf = 0;
    end else begin
      bit acc, pop;
      acc = (g > 0) && (g <= 4 - mq.size());
      pop = (mq.size() > 0) && ready;
      if (pop) begin
        $display("t=%0t pop iaddr=%h usage_before=%0d", $time, mq[0].iaddr, mq.size());
        void'(mq.pop_front());
      end
      if (acc) begin
        for (int k = 0; k < 2; k++) if (valid[k]) mq.push_back(lane_in[k]);
      end else if (g > 0) begin
        m_ovf = 1;
        m_drop = exp_drop_after(g);
      end else if (clr) m_ovf = 0;
      if (acc && clr) m_ovf = 0;
    end
    @(posedge clk);
    #1;
    valid = '0; flush = 0; clr = 0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({out_valid, usage, in_ready, overflow, dropped, head_obs} !== {1'b0, 3'd0, 1'b1, 1'b0, 16'd0, 80'd0})
      $display("FAIL reset got v=%b u=%0d ir=%b ov=%b dc=%0d head=%h want v=0 u=0 ir=1 ov=0 dc=0 head=0",
               out_valid, usage, in_ready, overflow, dropped, head_obs);
    else n_pass++;
    #4 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_in_order();
    logic [31:0] want [3] = '{32'h100, 32'h104, 32'h108};
    ready = 1;
    lane_in[0] = rnd_blk(32'h100); valid = 2'b01;
    tick();
    lane_in[0] = rnd_blk(32'h104); lane_in[1] = rnd_blk(32'h108); valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (!out_valid || out_iaddr !== want[i])
        $display("FAIL in_order[%0d] got v=%b iaddr=%h want v=1 iaddr=%h", i, out_valid, out_iaddr, want[i]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || usage !== 3'd0)
      $display("FAIL in_order_empty got v=%b u=%0d want v=0 u=0", out_valid, usage);
    else n_pass++;
  endtask

  task automatic test_compaction();
    ready = 0;
    lane_in[0] = rnd_blk(32'hDEAD); lane_in[1] = rnd_blk(32'h200); valid = 2'b10;
    tick();
    n_checks++;
    if (usage !== 3'd1 || out_iaddr !== 32'h200 || head_obs !== lane_in[1])
      $display("FAIL compaction got u=%0d iaddr=%h want u=1 iaddr=200", usage, out_iaddr);
    else n_pass++;
    ready = 1; tick();
  endtask

  task automatic test_overflow();
    int exp_dc;
    ready = 0;
    for (int i = 0; i < 2; i++) begin
      lane_in[0] = rnd_blk(32'h300 + 8*i); lane_in[1] = rnd_blk(32'h304 + 8*i); valid = 2'b11;
      tick();
    end
    n_checks++;
    if (usage !== 3'd4 || in_ready !== 1'b0)
      $display("FAIL ovf_full got u=%0d ir=%b want u=4 ir=0", usage, in_ready);
    else n_pass++;
    exp_dc = exp_drop_after(1);
    lane_in[0] = rnd_blk(32'h3FF); valid = 2'b01;
    tick();
    n_checks++;
    if (usage !== 3'd4 || overflow !== 1'b1 || dropped !== 16'(exp_dc))
      $display("FAIL ovf_drop got u=%0d ov=%b dc=%0d want u=4 ov=1 dc=%0d", usage, overflow, dropped, exp_dc);
    else n_pass++;
    clr = 1; tick();
    n_checks++;
    if (overflow !== 1'b0 || dropped !== 16'(exp_dc))
      $display("FAIL ovf_clear got ov=%b dc=%0d want ov=0 dc=%0d", overflow, dropped, exp_dc);
    else n_pass++;
    ready = 1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_back_to_back_wrap();
    flush = 1; tick();
    ready = 0;
    lane_in[0] = rnd_blk(32'h90); lane_in[1] = rnd_blk(32'h94); valid = 2'b11; tick();
    lane_in[0] = rnd_blk(32'h98); valid = 2'b01; tick();
    ready = 1;
    for (int i = 0; i < 3; i++) tick();
    ready = 0;
    lane_in[0] = rnd_blk(32'hA0); lane_in[1] = rnd_blk(32'hA4); valid = 2'b11;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_iaddr !== 32'hA0 || head_obs !== mq[0])
        $display("FAIL wrap_stall[%0d] got v=%b iaddr=%h want v=1 iaddr=a0", i, out_valid, out_iaddr);
      else n_pass++;
      if (i == 0) tick();
    end
    ready = 1; tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_iaddr !== 32'hA4)
      $display("FAIL wrap_second got v=%b iaddr=%h want v=1 iaddr=a4", out_valid, out_iaddr);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL wrap_drain got v=%b want v=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_flush_collision();
    ready = 0;
    for (int i = 0; i < 2; i++) begin
      lane_in[0] = rnd_blk(32'h500 + 8*i); lane_in[1] = rnd_blk(32'h504 + 8*i); valid = 2'b11; tick();
    end
    lane_in[0] = rnd_blk(32'h5FF); valid = 2'b01; tick();
    ready = 1; tick(); tick();
    n_checks++;
    if (usage !== 3'd2 || overflow !== 1'b1)
      $display("FAIL flush_pre got u=%0d ov=%b want u=2 ov=1", usage, overflow);
    else n_pass++;
    flush = 1; valid = 2'b11; ready = 1;
    lane_in[0] = rnd_blk(32'h600); lane_in[1] = rnd_blk(32'h604);
    tick();
    n_checks++;
    if (usage !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b1 || dropped !== 16'(m_drop))
      $display("FAIL flush_collision got u=%0d v=%b ov=%b dc=%0d want u=0 v=0 ov=1 dc=%0d",
               usage, out_valid, overflow, dropped, m_drop);
    else n_pass++;
    clr = 1; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      logic [2:0] u;
      u = 3'(mq.size());
      n_checks++;
      if ({out_valid, usage, in_ready, overflow, dropped} !==
          {mq.size() != 0, u, (4 - mq.size()) >= 2, m_ovf, 16'(m_drop)} ||
          (mq.size() != 0 && head_obs !== mq[0]))
        $display("FAIL random[%0d] got v=%b u=%0d ir=%b ov=%b dc=%0d iaddr=%h want u=%0d ov=%b dc=%0d iaddr=%h",
                 c, out_valid, usage, in_ready, overflow, dropped, out_iaddr, mq.size(), m_ovf, m_drop,
                 (mq.size() != 0) ? mq[0].iaddr : 32'h0);
      else n_pass++;
      valid = 2'($urandom_range(0, 3));
      ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 39) == 0);
      clr   = !flush && ($urandom_range(0, 29) == 0);
      lane_in[0] = rnd_blk($urandom); lane_in[1] = rnd_blk($urandom);
      tick();
    end
  endtask

  task automatic test_async_reset();
    flush = 1; tick();
    ready = 0;
    lane_in[0] = rnd_blk(32'h700); lane_in[1] = rnd_blk(32'h704); valid = 2'b11; tick();
    lane_in[0] = rnd_blk(32'h708); valid = 2'b01; tick();
    n_checks++;
    if (usage !== 3'd3)
      $display("FAIL areset_pre got u=%0d want u=3", usage);
    else n_pass++;
    #1 rst_n = 0;
    #1;
    n_checks++;
    if ({out_valid, usage, in_ready, overflow, dropped, head_obs} !== {1'b0, 3'd0, 1'b1, 1'b0, 16'd0, 80'd0})
      $display("FAIL areset got v=%b u=%0d ir=%b ov=%b dc=%0d head=%h want v=0 u=0 ir=1 ov=0 dc=0 head=0",
               out_valid, usage, in_ready, overflow, dropped, head_obs);
    else n_pass++;
    mq.delete(); m_ovf = 0; m_drop = 0;
    #1 rst_n = 1;
    ready = 1;
    @(posedge clk); #1;
    n_checks++;
    if (usage !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL areset_post got u=%0d v=%b want u=0 v=0", usage, out_valid);
    else n_pass++;
  endtask

  initial begin
    lane_in = '0;
    test_reset();
    test_in_order();
    test_compaction();
    test_overflow();
    test_back_to_back_wrap();
    test_flush_collision();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
